mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 10 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_pick.sv | 15 +
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner encodings, default widths and owner helper for the memory port arbiter.
package mem_port_arbiter_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
    typedef enum logic {OWNER_CORE, OWNER_DBG} owner_t;
    function automatic owner_t other_owner(input owner_t o);
        return o == OWNER_CORE ? OWNER_DBG : OWNER_CORE;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: core, debug and memory-side signals of the shared memory port.
// master = environment (core, debug loader, memory model), slave = arbiter.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = mem_port_arbiter_pkg::DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = mem_port_arbiter_pkg::DEF_ADDR_WIDTH
);
    logic                  core_req;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic                  core_gnt;
    logic                  core_done;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_done;
    logic [DATA_WIDTH-1:0] dbg_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata, mem_ready,
        input  core_gnt, core_done, core_rdata,
        input  dbg_gnt, dbg_done, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata, mem_ready,
        output core_gnt, core_done, core_rdata,
        output dbg_gnt, dbg_done, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// mem_arb_pick: combinational winner select; prio breaks ties when both requesters are eligible.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   core_el,
    input  logic   dbg_el,
    input  owner_t prio,
    output logic   any,
    output owner_t win
);
    always_comb begin
        any = core_el | dbg_el;
        win = (core_el && dbg_el) ? prio : (core_el ? OWNER_CORE : OWNER_DBG);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between core and debug with an IDLE/BUSY/DONE handshake FSM.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the core always wins ties.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    arb_state_t state;
    owner_t     owner;
    owner_t     prio;
    owner_t     win;
    logic       any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t rr_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= OWNER_CORE;
        else if (state == ARB_IDLE && any) rr_ptr <= other_owner(win);
    end
    assign prio = rr_ptr;
`else
    assign prio = OWNER_CORE;
`endif

    mem_arb_pick u_pick (
        .core_el (bus.core_req & ~bus.core_done),
        .dbg_el  (bus.dbg_req & ~bus.dbg_done),
        .prio    (prio),
        .any     (any),
        .win     (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB_IDLE;
            owner          <= OWNER_CORE;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.core_gnt   <= 1'b0;
            bus.dbg_gnt    <= 1'b0;
            bus.core_done  <= 1'b0;
            bus.dbg_done   <= 1'b0;
            bus.core_rdata <= '0;
            bus.dbg_rdata  <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (any) begin
                    state         <= ARB_BUSY;
                    owner         <= win;
                    bus.mem_en    <= 1'b1;
                    bus.mem_we    <= (win == OWNER_DBG) ? bus.dbg_we : bus.core_we;
                    bus.mem_addr  <= (win == OWNER_DBG) ? bus.dbg_addr : bus.core_addr;
                    bus.mem_wdata <= (win == OWNER_DBG) ? bus.dbg_wdata : bus.core_wdata;
                    bus.core_gnt  <= win == OWNER_CORE;
                    bus.dbg_gnt   <= win == OWNER_DBG;
                end
                ARB_BUSY: if (bus.mem_ready) begin
                    state         <= ARB_DONE;
                    bus.mem_en    <= 1'b0;
                    bus.core_gnt  <= 1'b0;
                    bus.dbg_gnt   <= 1'b0;
                    bus.core_done <= owner == OWNER_CORE;
                    bus.dbg_done  <= owner == OWNER_DBG;
                    if (!bus.mem_we && owner == OWNER_CORE) bus.core_rdata <= bus.mem_rdata;
                    if (!bus.mem_we && owner == OWNER_DBG) bus.dbg_rdata <= bus.mem_rdata;
                end
                default: begin
                    state         <= ARB_IDLE;
                    bus.core_done <= 1'b0;
                    bus.dbg_done  <= 1'b0;
                end
            endcase
        end
    end

    // Grants are exclusive and live exactly as long as the BUSY phase.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(bus.core_gnt && bus.dbg_gnt));
    a_gnt_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.core_gnt || bus.dbg_gnt) == (state == ARB_BUSY));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random core/debug/memory traffic checked cycle by cycle against a protocol-level model.
module tb_mem_port_arbiter;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();
    mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] mem [256];
    logic a_req [2];
    logic a_wait [2];
    op_t a_op [2];
    logic ready;
    logic [7:0] rdata;
    int m_phase, m_own, m_pref;
    op_t m_op;
    logic [7:0] exp_rd [2];
    int start_pct, drop_pct;
    bit hold_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.we = 1'($urandom_range(0, 1));
        o.addr = 8'($urandom_range(0, 15));
        o.wdata = 8'($urandom);
        return o;
    endfunction

    task automatic apply();
        bus.core_req = a_req[0];
        bus.core_we = a_op[0].we;
        bus.core_addr = a_op[0].addr;
        bus.core_wdata = a_op[0].wdata;
        bus.dbg_req = a_req[1];
        bus.dbg_we = a_op[1].we;
        bus.dbg_addr = a_op[1].addr;
        bus.dbg_wdata = a_op[1].wdata;
        bus.mem_ready = ready;
        bus.mem_rdata = rdata;
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_own = 0;
        m_pref = 0;
        m_op = '0;
        ready = 1'b0;
        rdata = 8'h00;
        for (int x = 0; x < 2; x++) begin
            exp_rd[x] = 8'h00;
            a_req[x] = 1'b0;
            a_wait[x] = 1'b0;
            a_op[x] = '0;
        end
    endtask

    // Phase 0 = port free, 1 = access in flight, 2 = completion pulse.
    task automatic advance();
        int w;
        case (m_phase)
            0: if (a_req[0] || a_req[1]) begin
                w = (a_req[0] && a_req[1]) ? (RR ? m_pref : 0) : (a_req[0] ? 0 : 1);
                m_own = w;
                m_op = a_op[w];
                m_phase = 1;
                m_pref = 1 - w;
            end
            1: if (ready) begin
                m_phase = 2;
                if (m_op.we) mem[m_op.addr] = m_op.wdata;
                else exp_rd[m_own] = mem[m_op.addr];
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare();
        chk("mem_en", 32'(bus.mem_en), 32'(m_phase == 1));
        chk("core_gnt", 32'(bus.core_gnt), 32'(m_phase == 1 && m_own == 0));
        chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(m_phase == 1 && m_own == 1));
        chk("core_done", 32'(bus.core_done), 32'(m_phase == 2 && m_own == 0));
        chk("dbg_done", 32'(bus.dbg_done), 32'(m_phase == 2 && m_own == 1));
        chk("core_rdata", 32'(bus.core_rdata), 32'(exp_rd[0]));
        chk("dbg_rdata", 32'(bus.dbg_rdata), 32'(exp_rd[1]));
        if (m_phase == 1) begin
            chk("mem_we", 32'(bus.mem_we), 32'(m_op.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_op.addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_op.wdata));
        end
    endtask

    task automatic drive();
        for (int x = 0; x < 2; x++) begin
            if (m_phase == 2 && m_own == x) a_wait[x] = 1'b0;
            if (!a_wait[x]) begin
                a_req[x] = 1'b0;
                if ($urandom_range(0, 99) < start_pct) begin
                    a_wait[x] = 1'b1;
                    a_req[x] = 1'b1;
                    a_op[x] = rand_op();
                end
            end else if (m_phase == 1 && m_own == x && $urandom_range(0, 99) < drop_pct) begin
                a_req[x] = 1'b0;
            end
        end
        ready = (m_phase == 1 && !hold_ready) ? ($urandom_range(0, 2) == 0) : 1'b0;
        rdata = ready ? mem[m_op.addr] : 8'($urandom);
        apply();
    endtask

    task automatic cycle();
        @(negedge clk);
        advance();
        compare();
        drive();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        model_reset();
        apply();
        start_pct = 30;
        drop_pct = 10;
        hold_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_gnt", 32'({bus.core_gnt, bus.dbg_gnt}), 32'h0);
        chk("rst_done", 32'({bus.core_done, bus.dbg_done}), 32'h0);
        chk("rst_rdata", 32'({bus.core_rdata, bus.dbg_rdata}), 32'h0);
        rst_n = 1'b1;
        drive();
        repeat (1500) cycle();
        start_pct = 100;
        drop_pct = 0;
        repeat (400) cycle();
        start_pct = 0;
        for (int i = 0; i < 200 && (m_phase != 0 || a_wait[0] || a_wait[1]); i++) cycle();
        // Core read left stalled in BUSY, then reset lands asynchronously mid-cycle.
        hold_ready = 1'b1;
        a_req[0] = 1'b1;
        a_wait[0] = 1'b1;
        a_op[0] = '{we: 1'b0, addr: 8'h05, wdata: 8'h00};
        apply();
        cycle();
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("async_rst_core_gnt", 32'(bus.core_gnt), 32'h0);
        chk("async_rst_core_done", 32'(bus.core_done), 32'h0);
        chk("async_rst_rdata", 32'({bus.core_rdata, bus.dbg_rdata}), 32'h0);
        model_reset();
        hold_ready = 1'b0;
        apply();
        @(negedge clk);
        rst_n = 1'b1;
        start_pct = 30;
        drop_pct = 10;
        drive();
        repeat (1500) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
